// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I
// width codes, byte-enable generation and access legality.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width lives in funct3[1:0]; the sign bit does not affect the lanes touched.
  function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   be_for = 4'b0001 << addr_lo;
      2'b01:   be_for = 4'b0011 << addr_lo;
      default: be_for = 4'b1111;
    endcase
  endfunction

  function automatic logic access_legal(input logic is_load, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    access_legal = 1'b1;
      F3_H:    access_legal = ~addr_lo[0];
      F3_W:    access_legal = (addr_lo == 2'b00);
      F3_BU:   access_legal = is_load;
      F3_HU:   access_legal = is_load & ~addr_lo[0];
      default: access_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering between a 32-bit register value and a word-wide memory bus:
// store replication with byte enables, and load lane select with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first, full case with default); a missed path infers a latch.
  always_comb begin
    wdata     = store_data;
    load_data = rdata;
    be        = be_for(funct3, addr_lo);
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

    case (funct3[1:0])
      2'b00: begin
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_lane[7] & ~funct3[2]}}, byte_lane};
      end
      2'b01: begin
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_lane[15] & ~funct3[2]}}, half_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I execute-to-memory stage: captures one load/store, runs a req/ready
// access on a word-addressed port and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32  // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] ALUout,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [4:0]            RdIn,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic [4:0]            RdOut,
  output logic                  done,
  output logic                  lsu_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t state, state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        we_q;

  logic        take;
  logic        legal;
  logic        accept;
  logic [3:0]  be_w;
  logic [31:0] load_w;

  // Both-direction requests are still taken so they can be reported as errors.
  assign take   = valid_in & (MemRead | MemWrite);
  assign legal  = (MemRead ^ MemWrite) & access_legal(MemRead, funct3, ALUout[1:0]);
  assign accept = take & legal;

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (wdata_q),
    .rdata      (mem_rdata),
    .wdata      (mem_wdata),
    .be         (be_w),
    .load_data  (load_w)
  );

  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_we   = we_q;
  assign mem_be   = mem_req ? be_w : 4'b0000;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_req    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ACCESS;
          stall      = 1'b1;
        end
      end
      ACCESS: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_next = DONE;
      end
      DONE: begin
        stall      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      lsu_err <= 1'b0;
    end else begin
      lsu_err <= (state == IDLE) & take & ~legal;
      if ((state == IDLE) && take) begin
        addr_q  <= ALUout;
        wdata_q <= WriteData;
        f3_q    <= funct3;
        rd_q    <= RdIn;
        we_q    <= MemWrite;
      end
    end
  end

  // Completion data is held until the next access finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadData <= '0;
      RdOut    <= '0;
    end else if ((state == ACCESS) && mem_ready) begin
      ReadData <= we_q ? 32'h0 : load_w;
      RdOut    <= we_q ? 5'd0 : rd_q;
    end
  end

endmodule
